// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - command/result handshake bundle for alu_seq_param
interface alu_seq_param_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           command;
  logic [2*WIDTH-1:0]   out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 carry;
  logic                 zero;
  logic                 div0;

  modport master (
    output in_valid, a, b, command, out_ready,
    input  in_ready, out, out_valid, carry, zero, div0
  );

  modport slave (
    input  in_valid, a, b, command, out_ready,
    output in_ready, out, out_valid, carry, zero, div0
  );
endinterface

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - registered 16-command ALU with iterative WIDTH-cycle multiply/divide
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  alu_seq_param_if.slave  bus
);
  localparam int OW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_INC  = 4'h1;
  localparam logic [3:0] CMD_SUB  = 4'h2;
  localparam logic [3:0] CMD_DEC  = 4'h3;
  localparam logic [3:0] CMD_MUL  = 4'h4;
  localparam logic [3:0] CMD_DIV  = 4'h5;
  localparam logic [3:0] CMD_SHL  = 4'h6;
  localparam logic [3:0] CMD_SHR  = 4'h7;
  localparam logic [3:0] CMD_AND  = 4'h8;
  localparam logic [3:0] CMD_OR   = 4'h9;
  localparam logic [3:0] CMD_INV  = 4'hA;
  localparam logic [3:0] CMD_NAND = 4'hB;
  localparam logic [3:0] CMD_NOR  = 4'hC;
  localparam logic [3:0] CMD_XOR  = 4'hD;
  localparam logic [3:0] CMD_XNOR = 4'hE;
  localparam logic [3:0] CMD_BUF  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     acc_q, acc_d, out_q, out_d;
  logic              carry_q, carry_d, zero_q, zero_d, div0_q, div0_d;

  logic              in_ready_w;
  logic [OW-1:0]     sc_res;
  logic              sc_carry;
  logic [WIDTH:0]    sc_sum;
  logic [WIDTH:0]    mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [OW-1:0]     step;

  assign in_ready_w = rst_n && enable && (state_q == S_IDLE);

  // Single-cycle results come straight from the bus so they can be registered on the accept edge.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_sum   = '0;
    case (bus.command)
      CMD_ADD: begin
        sc_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        sc_res   = {{(WIDTH-1){1'b0}}, sc_sum};
        sc_carry = sc_sum[WIDTH];
      end
      CMD_INC: begin
        sc_sum   = {1'b0, bus.a} + {{WIDTH{1'b0}}, 1'b1};
        sc_res   = {{(WIDTH-1){1'b0}}, sc_sum};
        sc_carry = sc_sum[WIDTH];
      end
      CMD_SUB: begin
        sc_res   = {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
        sc_carry = (bus.a < bus.b);
      end
      CMD_DEC: begin
        sc_res   = {{WIDTH{1'b0}}, bus.a} - {{(OW-1){1'b0}}, 1'b1};
        sc_carry = (bus.a == '0);
      end
      CMD_DIV:  sc_res = {bus.a, {WIDTH{1'b1}}};
      CMD_SHL:  sc_res = {{(WIDTH-1){1'b0}}, bus.a, 1'b0};
      CMD_SHR:  sc_res = {{WIDTH{1'b0}}, 1'b0, bus.a[WIDTH-1:1]};
      CMD_AND:  sc_res = {{WIDTH{1'b0}}, bus.a & bus.b};
      CMD_OR:   sc_res = {{WIDTH{1'b0}}, bus.a | bus.b};
      CMD_INV:  sc_res = {{WIDTH{1'b0}}, ~bus.a};
      CMD_NAND: sc_res = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
      CMD_NOR:  sc_res = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
      CMD_XOR:  sc_res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      CMD_XNOR: sc_res = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
      CMD_BUF:  sc_res = {{WIDTH{1'b0}}, bus.a};
      default:  sc_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[OW-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    div_shift = {acc_q[OW-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = !div_diff[WIDTH];
    if (cmd_q == CMD_MUL) begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_w) begin
          a_d   = bus.a;
          b_d   = bus.b;
          cmd_d = bus.command;
          cnt_d = '0;
          if (bus.command == CMD_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            state_d = S_BUSY;
          end else if (bus.command == CMD_DIV && bus.b != '0) begin
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            state_d = S_BUSY;
          end else begin
            out_d   = sc_res;
            carry_d = sc_carry;
            zero_d  = (sc_res == '0);
            div0_d  = (bus.command == CMD_DIV);
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_d   = step;
          carry_d = 1'b0;
          zero_d  = (step == '0);
          div0_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.div0      = div0_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - randomized and directed bench for alu_seq_param at WIDTH 8, 4 and 16
module tb_alu_seq_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, rst_nx;
  int   checks = 0, failures = 0;
  int   or_mode = 1, en_mode = 1;
  bit   done4 = 1'b0, done16 = 1'b0;

  alu_seq_param_if #(.WIDTH(8))  bus ();
  alu_seq_param_if #(.WIDTH(4))  b4 ();
  alu_seq_param_if #(.WIDTH(16)) b16 ();

  alu_seq_param #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n),  .enable(enable), .bus(bus));
  alu_seq_param #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_nx), .enable(1'b1),   .bus(b4));
  alu_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_nx), .enable(1'b1),   .bus(b16));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: result, carry/borrow, div0 and latency straight from the command definitions.
  function automatic void mdl(input int w, input longint a, input longint b, input int cmd,
                              output longint r, output bit c, output bit d0, output int lat);
    longint m  = (longint'(1) << w) - 1;
    longint om = (longint'(1) << (2 * w)) - 1;
    r = 0; c = 1'b0; d0 = 1'b0; lat = 1;
    case (cmd)
      0:  begin r = a + b; c = (r > m); end
      1:  begin r = a + 1; c = (r > m); end
      2:  begin r = (a - b) & om; c = (a < b); end
      3:  begin r = (a - 1) & om; c = (a == 0); end
      4:  begin r = a * b; lat = w + 1; end
      5:  if (b == 0) begin r = (a << w) | m; d0 = 1'b1; end
          else begin r = ((a % b) << w) | (a / b); lat = w + 1; end
      6:  r = a << 1;
      7:  r = a >> 1;
      8:  r = a & b;
      9:  r = a | b;
      10: r = ~a & m;
      11: r = ~(a & b) & m;
      12: r = ~(a | b) & m;
      13: r = a ^ b;
      14: r = ~(a ^ b) & m;
      default: r = a;
    endcase
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    enable = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (or_mode == 2) ? ($urandom_range(0, 3) != 0) : (or_mode == 1);
      enable        = (en_mode == 2) ? ($urandom_range(0, 7) != 0) : (en_mode == 1);
    end
  end

  initial begin : cmp
    bit pend, erdy, ec, ed0;
    int due, elat;
    longint er;
    pend = 1'b0; due = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outs", {bus.in_ready, bus.out_valid, bus.out, bus.carry, bus.zero, bus.div0}, 0);
        pend = 1'b0;
      end else begin
        erdy = enable && !pend;
        chk("in_ready", bus.in_ready, erdy);
        chk("out_valid", bus.out_valid, pend && due == 0);
        if (pend && due == 0) begin
          chk("out", bus.out, er);
          chk("carry", bus.carry, ec);
          chk("zero", bus.zero, er == 0);
          chk("div0", bus.div0, ed0);
          if (bus.out_ready) pend = 1'b0;
        end else if (pend) begin
          due--;
        end
        if (erdy && bus.in_valid) begin
          mdl(8, bus.a, bus.b, bus.command, er, ec, ed0, elat);
          pend = 1'b1;
          due  = elat - 1;
        end
      end
    end
  end

  task automatic send(input int a, input int b, input int cmd);
    int n = 0;
    bus.in_valid = 1'b1; bus.a = 8'(a); bus.b = 8'(b); bus.command = 4'(cmd);
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic lit(input int a, input int b, input int cmd, input logic [15:0] eo,
                     input int elat, input logic [2:0] ef, input string nm);
    int n = 0;
    send(a, b, cmd);
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 40);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_out"}, bus.out, eo);
    chk({nm, "_flags"}, {bus.carry, bus.zero, bus.div0}, ef);
    @(posedge clk); #2;
  endtask

  initial begin
    rst_nx = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_nx = 1'b1;
  end

  initial begin : w4_test
    longint r; bit c, d0; int lat, n, a, b, cmd;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.a = '0; b4.b = '0; b4.command = '0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      cmd = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 4 : 5);
      a = (i < 3) ? 15 : $urandom_range(0, 15);
      b = (i < 3) ? 15 : ((i % 7 == 5) ? 0 : $urandom_range(0, 15));
      b4.in_valid = 1'b1; b4.a = 4'(a); b4.b = 4'(b); b4.command = 4'(cmd);
      @(negedge clk); chk("w4_ready", b4.in_ready, 1);
      @(posedge clk); #2 b4.in_valid = 1'b0;
      mdl(4, a, b, cmd, r, c, d0, lat);
      n = 0;
      do begin @(negedge clk); n++; end while (!b4.out_valid && n < 40);
      chk("w4_lat", n, lat); chk("w4_out", b4.out, r);
      chk("w4_flags", {b4.carry, b4.div0}, {c, d0});
      @(posedge clk); #2 b4.out_ready = 1'b1;
      @(posedge clk); #2 b4.out_ready = 1'b0;
    end
    done4 = 1'b1;
  end

  initial begin : w16_test
    longint r; bit c, d0; int lat, n, a, b, cmd;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.a = '0; b16.b = '0; b16.command = '0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      cmd = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 4 : 5);
      a = (i < 3) ? 65535 : $urandom_range(0, 65535);
      b = (i < 3) ? 65535 : ((i % 7 == 5) ? 0 : $urandom_range(0, 65535));
      b16.in_valid = 1'b1; b16.a = 16'(a); b16.b = 16'(b); b16.command = 4'(cmd);
      @(negedge clk); chk("w16_ready", b16.in_ready, 1);
      @(posedge clk); #2 b16.in_valid = 1'b0;
      mdl(16, a, b, cmd, r, c, d0, lat);
      n = 0;
      do begin @(negedge clk); n++; end while (!b16.out_valid && n < 40);
      chk("w16_lat", n, lat); chk("w16_out", b16.out, r);
      chk("w16_flags", {b16.carry, b16.div0}, {c, d0});
      @(posedge clk); #2 b16.out_ready = 1'b1;
      @(posedge clk); #2 b16.out_ready = 1'b0;
    end
    done16 = 1'b1;
  end

  initial begin : main
    longint r; bit c, d0; int lat, n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.command = '0;

    mdl(8, 25, 17, 0, r, c, d0, lat);   chk("model_add", {r, c}, {64'd42, 1'b0});
    mdl(8, 255, 1, 0, r, c, d0, lat);   chk("model_add_c", {r, c}, {64'h100, 1'b1});
    mdl(8, 255, 255, 4, r, c, d0, lat); chk("model_mul", r, 64'hFE01); chk("model_mul_lat", lat, 9);
    mdl(8, 200, 7, 5, r, c, d0, lat);   chk("model_div", r, 64'h041C);
    mdl(8, 5, 0, 5, r, c, d0, lat);     chk("model_div0", {r, d0}, {64'h05FF, 1'b1});
    mdl(8, 10, 20, 2, r, c, d0, lat);   chk("model_sub", {r, c}, {64'hFFF6, 1'b1});

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    lit(25, 17, 0, 16'd42, 1, 3'b000, "add");
    lit(255, 1, 0, 16'h0100, 1, 3'b100, "add_carry");
    lit(255, 255, 4, 16'hFE01, 9, 3'b000, "mul");
    lit(200, 7, 5, 16'h041C, 9, 3'b000, "div");
    lit(5, 0, 5, 16'h05FF, 1, 3'b001, "div_by0");
    lit(10, 20, 2, 16'hFFF6, 1, 3'b100, "sub");
    lit(8'hAA, 8'hAA, 13, 16'h0000, 1, 3'b010, "xor");

    // Held result under backpressure while a competing command is offered.
    or_mode = 0;
    @(posedge clk); #2;
    send(255, 255, 4);
    bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.command = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 40);
    chk("bp_lat", n, 9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", bus.out, 16'hFE01);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    @(posedge clk); #2;
    or_mode = 1; bus.in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.out_valid && n < 10);
    chk("bp_ready_after_pop", {bus.out_valid, bus.in_ready}, 2'b01);
    @(posedge clk); #2;

    // Reset in the middle of a multiply.
    send(255, 255, 4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", {bus.in_ready, bus.out_valid, bus.out, bus.carry, bus.zero, bus.div0}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    repeat (15) begin @(negedge clk); if (bus.out_valid) n++; end
    chk("rst_no_result", n, 0);
    @(posedge clk); #2;

    // enable low blocks acceptance.
    en_mode = 0;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.command = 4'h0;
    n = 0;
    repeat (4) begin @(negedge clk); if (bus.in_ready || bus.out_valid) n++; end
    chk("en0_blocked", n, 0);
    @(posedge clk); #2;
    bus.in_valid = 1'b0; en_mode = 1;
    @(posedge clk); #2;

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int cmd = 0; cmd < 16; cmd++)
          send(a, b, cmd);

    or_mode = 2; en_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      send($urandom_range(0, 255), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255),
           $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) begin
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.command = 4'($urandom);
        @(posedge clk); #2;
      end
    end

    or_mode = 1; en_mode = 1;
    repeat (20) @(posedge clk);
    n = 0;
    while (!(done4 && done16) && n < 5000) begin @(posedge clk); n++; end
    chk("sub_done", {done4, done16}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
